// File: rtl/apb_uart_tx.sv
// APB slave UART transmitter: TX FIFO feeding a baud-rate serialiser (8N1).
// Define UART_PARITY_EN to insert an even-parity bit (8E1 frames).
module apb_uart_tx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        TXD,
  output logic        tx_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t state, state_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          full, empty;
  logic          ovf;
  logic [15:0]   baud;
  logic [15:0]   cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          pop, push, push_req;
  logic          acc, wr, rd;
  logic          baud_wr, stat_rd;
  logic          bit_end, busy;
  logic [4:0]    cnt5;
  logic [1:0]    sel;
  logic          unused_bits;

  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

  assign sel      = PADDR[3:2];
  assign acc      = PSEL & PENABLE;
  assign wr       = acc & PWRITE;
  assign rd       = acc & ~PWRITE;
  assign PREADY   = acc;
  assign push_req = wr && (sel == 2'd0);
  assign baud_wr  = wr && (sel == 2'd2);
  assign stat_rd  = rd && (sel == 2'd1);
  assign push     = push_req && (!full || pop);

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign bit_end = (state != S_IDLE) && (cnt == 16'd0);
  assign busy    = (state != S_IDLE);
  assign tx_irq  = empty && (state == S_IDLE);
  assign cnt5    = 5'(count);

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      unique case (sel)
        2'd1: begin
          PRDATA[0]   = busy;
          PRDATA[1]   = full;
          PRDATA[2]   = empty;
          PRDATA[3]   = ovf;
          PRDATA[7:4] = cnt5[3:0];
`ifdef UART_PARITY_EN
          PRDATA[8]   = 1'b1;
`endif
        end
        2'd2:    PRDATA[15:0] = baud;
        default: PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem[wp] <= PWDATA[7:0];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      baud  <= 16'(DEFAULT_DIV);
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // a set from a dropped push wins over a clear by STATUS read
      if (push_req && full && !pop) ovf <= 1'b1;
      else if (stat_rd)             ovf <= 1'b0;
      if (baud_wr)
        baud <= (PWDATA[15:0] == 16'd0) ? 16'd1 : PWDATA[15:0];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (!empty) state_n = S_START;
      S_START: if (bit_end) state_n = S_DATA;
      S_DATA:
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
          state_n = S_PAR;
`else
          state_n = S_STOP;
`endif
        end
      S_PAR:   if (bit_end) state_n = S_STOP;
      S_STOP:
        if (bit_end) state_n = empty ? S_IDLE : S_START;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    pop = !empty && ((state == S_IDLE) || (state == S_STOP && bit_end));
    TXD = 1'b1;
    unique case (state)
      S_IDLE:  TXD = 1'b1;
      S_START: TXD = 1'b0;
      S_DATA:  TXD = shreg[0];
      S_PAR:   TXD = par_bit;
      S_STOP:  TXD = 1'b1;
      default: TXD = 1'b1;
    endcase
  end

  // bit timer reloads from the live BAUD value only at bit boundaries
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (pop) begin
        shreg   <= mem[rp];
        par_bit <= ^mem[rp];
      end else if (state == S_DATA && bit_end) begin
        shreg <= {1'b0, shreg[7:1]};
      end
      if (pop || bit_end)      cnt <= baud - 16'd1;
      else if (state != S_IDLE) cnt <= cnt - 16'd1;
      if (state == S_START)
        bit_idx <= '0;
      else if (state == S_DATA && bit_end)
        bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Directed bench for apb_uart_tx: APB register access and TXD bit timing.
// Expected frames are built from the data byte; honours UART_PARITY_EN.
module tb_apb_uart_tx;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, TXD, tx_irq;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_q[$];
  logic [31:0] rdat;
  logic        last_rdy;
  logic [31:0] setup_prd;

  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_BAUD = 32'h8;
  localparam logic [31:0] A_RSV  = 32'hC;
`ifdef UART_PARITY_EN
  localparam logic [31:0] PBIT = 32'h100;
`else
  localparam logic [31:0] PBIT = 32'h0;
`endif

  apb_uart_tx dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .TXD     (TXD),
    .tx_irq  (tx_irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    #1 setup_prd = PRDATA;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    last_rdy = PREADY;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic add_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_PARITY_EN
    exp_q.push_back(^d);
`endif
    exp_q.push_back(1'b1);
  endtask

  // starts one cycle after a DATA write edge: TXD must still be idle then
  task automatic check_frame(input int baud, input string tag);
    bit b;
    @(negedge PCLK);
    chk({tag, "_lat"}, {31'b0, TXD}, 32'd1);
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      for (int c = 0; c < baud; c++) begin
        @(negedge PCLK);
        chk(tag, {31'b0, TXD}, {31'b0, b});
      end
    end
    chk({tag, "_irq0"}, {31'b0, tx_irq}, 32'd0);
    @(negedge PCLK);
    chk({tag, "_irq1"}, {31'b0, tx_irq}, 32'd1);
    chk({tag, "_idle"}, {31'b0, TXD}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    #1 PRESETn = 1'b0;
    #1;
    chk("rst_txd", {31'b0, TXD}, 32'd1);
    chk("rst_irq", {31'b0, tx_irq}, 32'd1);
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  initial begin
    PRESETn = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    last_rdy = 1'b0;
    setup_prd = '0;
    #3;
    chk("rst_txd", {31'b0, TXD}, 32'd1);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pready", {31'b0, PREADY}, 32'd0);
    chk("rst_irq", {31'b0, tx_irq}, 32'd1);
    @(negedge PCLK);
    PRESETn = 1'b1;

    apb_read(A_STAT, rdat);
    chk("stat_rst", rdat, 32'h4 | PBIT);
    chk("pready_acc", {31'b0, last_rdy}, 32'd1);
    chk("prdata_setup", setup_prd, 32'd0);
    apb_read(A_BAUD, rdat);
    chk("baud_rst", rdat, 32'd16);

    apb_write(A_BAUD, 32'h0);
    apb_read(A_BAUD, rdat);
    chk("baud_zero", rdat, 32'd1);
    apb_write(A_RSV, 32'hFFFF_FFFF);
    apb_read(A_RSV, rdat);
    chk("rsv_read", rdat, 32'd0);
    apb_read(A_DATA, rdat);
    chk("data_read", rdat, 32'd0);

    // single frame 0xA5 at BAUD=4 with a STATUS read mid-frame
    apb_write(A_BAUD, 32'd4);
    add_frame(8'hA5);
    apb_write(A_DATA, 32'hA5);
    fork
      check_frame(4, "a5");
      begin
        repeat (6) @(negedge PCLK);
        apb_read(A_STAT, rdat);
        chk("a5_busy", rdat & 32'h1, 32'h1);
      end
    join

    // back-to-back frames at BAUD=2
    apb_write(A_BAUD, 32'd2);
    add_frame(8'h55);
    add_frame(8'h0F);
    apb_write(A_DATA, 32'h55);
    fork
      check_frame(2, "b2b");
      apb_write(A_DATA, 32'h0F);
    join

    // parity / frame length at BAUD=1
    apb_write(A_BAUD, 32'd1);
    add_frame(8'h07);
    apb_write(A_DATA, 32'h07);
    check_frame(1, "par07");

    // BAUD change during the start bit
    apb_write(A_BAUD, 32'd4);
    apb_write(A_DATA, 32'h55);
    fork
      apb_write(A_BAUD, 32'd8);
      begin
        @(negedge PCLK);
        for (int c = 0; c < 4; c++) begin
          @(negedge PCLK);
          chk("midbaud_start", {31'b0, TXD}, 32'd0);
        end
        for (int b = 0; b < 4; b++)
          for (int c = 0; c < 8; c++) begin
            @(negedge PCLK);
            chk("midbaud_bit", {31'b0, TXD}, (b % 2 == 0) ? 32'd1 : 32'd0);
          end
      end
    join
    do_reset();

    // overflow: first byte is popped at once, so the tenth write overflows
    apb_write(A_BAUD, 32'd1000);
    for (int i = 0; i < 9; i++) apb_write(A_DATA, 32'(i));
    apb_read(A_STAT, rdat);
    chk("full_no_ovf", rdat, 32'h83 | PBIT);
    apb_write(A_DATA, 32'hEE);
    apb_read(A_STAT, rdat);
    chk("ovf_set", rdat, 32'h8B | PBIT);
    apb_read(A_STAT, rdat);
    chk("ovf_clr", rdat, 32'h83 | PBIT);
    @(negedge PCLK);
    chk("mid_frame_txd", {31'b0, TXD}, 32'd0);
    do_reset();
    apb_read(A_STAT, rdat);
    chk("stat_after_rst", rdat, 32'h4 | PBIT);
    apb_read(A_BAUD, rdat);
    chk("baud_after_rst", rdat, 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
